// File: rtl/instr_inv_if.sv
// Invalidation stream bundle: store-path request side plus the
// icache and branch-predictor delivery/ack channels.
interface instr_inv_if;
  logic        inv_valid;
  logic [29:0] inv_addr;
  logic        inv_ready;
  logic        ic_inv_valid;
  logic [31:0] ic_inv_addr;
  logic        ic_inv_ack;
  logic        bp_inv_valid;
  logic [31:0] bp_inv_addr;
  logic        bp_inv_ack;
  logic        queue_empty;

  modport master (
    output inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
    input  inv_ready, ic_inv_valid, ic_inv_addr,
    input  bp_inv_valid, bp_inv_addr, queue_empty
  );

  modport slave (
    input  inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
    output inv_ready, ic_inv_valid, ic_inv_addr,
    output bp_inv_valid, bp_inv_addr, queue_empty
  );
endinterface

// File: rtl/instr_inv_queue.sv
// Line-granular invalidation FIFO feeding icache and branch predictor;
// an entry pops only once both consumers have taken it.
module instr_inv_queue #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  instr_inv_if.slave bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int OW   = $clog2(LINE_W);
  localparam int LA_W = 30 - OW;
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [LA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic            r_ic_done;
  logic            r_bp_done;

  logic [LA_W-1:0] w_line;
  logic [LA_W-1:0] w_last;
  logic            w_nonempty;
  logic            w_acc;
  logic            w_can_coal;
  logic            w_coal;
  logic            w_push;
  logic            w_ic_ack;
  logic            w_bp_ack;
  logic            w_pop;
  logic            w_unused;

  assign w_line     = bus.inv_addr[29:OW];
  assign w_unused   = &{1'b0, bus.inv_addr[OW-1:0]};
  assign w_last     = r_mem[r_wptr - PW'(1)];
  assign w_nonempty = (r_count != '0);
  assign w_acc      = bus.inv_valid && bus.inv_ready;

  // A half-served single entry must not absorb a newer store.
  assign w_can_coal = (r_count >= (PW+1)'(2)) ||
                      ((r_count == (PW+1)'(1)) &&
                       !r_ic_done && !r_bp_done);
  assign w_coal   = w_acc && w_can_coal && (w_line == w_last);
  assign w_push   = w_acc && !w_coal;
  assign w_ic_ack = bus.ic_inv_ack && bus.ic_inv_valid;
  assign w_bp_ack = bus.bp_inv_ack && bus.bp_inv_valid;
  assign w_pop    = w_nonempty &&
                    (r_ic_done || w_ic_ack) &&
                    (r_bp_done || w_bp_ack);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ic_done <= 1'b0;
      r_bp_done <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (PW+1)'(1);
      if (w_pop) begin
        r_ic_done <= 1'b0;
        r_bp_done <= 1'b0;
      end else begin
        if (w_ic_ack)
          r_ic_done <= 1'b1;
        if (w_bp_ack)
          r_bp_done <= 1'b1;
      end
    end
  end

  assign bus.inv_ready    = (r_count != C_FULL);
  assign bus.ic_inv_valid = w_nonempty && !r_ic_done;
  assign bus.bp_inv_valid = w_nonempty && !r_bp_done;
  assign bus.ic_inv_addr  = {r_mem[r_rptr], (OW+2)'(0)};
  assign bus.bp_inv_addr  = {r_mem[r_rptr], (OW+2)'(0)};
  assign bus.queue_empty  = !w_nonempty;

endmodule

// File: tb/tb_instr_inv_queue.sv
// Random plus directed stimulus against a queue-based model of the
// invalidation FIFO with per-consumer completion tracking.
module tb_instr_inv_queue;

  localparam int DEPTH  = 4;
  localparam int LINE_W = 4;
  localparam int OW     = $clog2(LINE_W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_inv_if bus();

  instr_inv_queue #(
    .DEPTH (DEPTH),
    .LINE_W(LINE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned mq[$];
  bit          m_icd;
  bit          m_bpd;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit icv;
    bit bpv;
    icv = (mq.size() != 0) && !m_icd;
    bpv = (mq.size() != 0) && !m_bpd;
    check("inv_ready", 32'(bus.inv_ready), 32'(mq.size() != DEPTH));
    check("ic_valid", 32'(bus.ic_inv_valid), 32'(icv));
    check("bp_valid", 32'(bus.bp_inv_valid), 32'(bpv));
    check("empty", 32'(bus.queue_empty), 32'(mq.size() == 0));
    if (mq.size() != 0) begin
      check("ic_addr", bus.ic_inv_addr, mq[0] << (OW + 2));
      check("bp_addr", bus.bp_inv_addr, mq[0] << (OW + 2));
    end
  endtask

  task automatic step(bit v, logic [29:0] a, bit ia, bit ba, bit r);
    bit acc, icv, bpv, ica, bpa, pop, coal;
    int unsigned line;
    @(negedge clk);
    compare();
    bus.inv_valid  = v;
    bus.inv_addr   = a;
    bus.ic_inv_ack = ia;
    bus.bp_inv_ack = ba;
    rst            = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_icd = 0;
      m_bpd = 0;
    end else begin
      line = 32'(a) >> OW;
      acc  = v && (mq.size() != DEPTH);
      icv  = (mq.size() != 0) && !m_icd;
      bpv  = (mq.size() != 0) && !m_bpd;
      ica  = ia && icv;
      bpa  = ba && bpv;
      pop  = (mq.size() != 0) && (m_icd || ica) && (m_bpd || bpa);
      coal = acc && (mq.size() != 0) && (line == mq[$]) &&
             (mq.size() >= 2 || (!m_icd && !m_bpd));
      if (pop) begin
        void'(mq.pop_front());
        m_icd = 0;
        m_bpd = 0;
      end else begin
        m_icd = m_icd || ica;
        m_bpd = m_bpd || bpa;
      end
      if (acc && !coal)
        mq.push_back(line);
    end
  endtask

  initial begin
    bus.inv_valid  = 0;
    bus.inv_addr   = '0;
    bus.ic_inv_ack = 0;
    bus.bp_inv_ack = 0;
    repeat (2) @(posedge clk);

    // single request, same-cycle acks
    step(1, 30'h2000_0005, 0, 0, 0);
    #1;
    check("tp1_icv", 32'(bus.ic_inv_valid), 32'd1);
    check("tp1_bpv", 32'(bus.bp_inv_valid), 32'd1);
    check("tp1_ic_addr", bus.ic_inv_addr, 32'h8000_0010);
    check("tp1_bp_addr", bus.bp_inv_addr, 32'h8000_0010);
    step(0, '0, 1, 1, 0);
    #1;
    check("tp1_empty", 32'(bus.queue_empty), 32'd1);

    // staggered acks
    step(1, 30'h0000_0123, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    #1;
    check("stag_icv", 32'(bus.ic_inv_valid), 32'd0);
    check("stag_bpv", 32'(bus.bp_inv_valid), 32'd1);
    repeat (3) step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    #1;
    check("stag_empty", 32'(bus.queue_empty), 32'd1);

    // coalescing into one line
    step(1, 30'h40, 0, 0, 0);
    step(1, 30'h41, 0, 0, 0);
    step(1, 30'h43, 0, 0, 0);
    #1;
    check("coal_addr", bus.ic_inv_addr, 32'h0000_0100);
    step(0, '0, 1, 1, 0);
    #1;
    check("coal_one", 32'(bus.queue_empty), 32'd1);
    step(1, 30'h40, 0, 0, 0);
    step(1, 30'h80, 0, 0, 0);
    step(1, 30'h41, 0, 0, 0);
    repeat (3) step(0, '0, 1, 1, 0);
    #1;
    check("three_drained", 32'(bus.queue_empty), 32'd1);

    // partial-serve guard
    step(1, 30'h40, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, 30'h41, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    #1;
    check("guard_icv", 32'(bus.ic_inv_valid), 32'd1);
    check("guard_bpv", 32'(bus.bp_inv_valid), 32'd1);
    check("guard_addr", bus.bp_inv_addr, 32'h0000_0100);
    step(0, '0, 1, 1, 0);

    // full, then drain across wrap
    for (int i = 1; i <= 5; i++) begin
      step(1, 30'(i * 16), 0, 0, 0);
      if (i == 4) begin
        #1;
        check("full_ready", 32'(bus.inv_ready), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fifo_order", bus.ic_inv_addr, 32'((i + 1) * 64));
      step(0, '0, 1, 1, 0);
    end

    // reset while half-acked
    for (int i = 0; i < 3; i++) step(1, 30'(i * 8), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    #1;
    check("rst_icv", 32'(bus.ic_inv_valid), 32'd0);
    check("rst_bpv", 32'(bus.bp_inv_valid), 32'd0);
    check("rst_empty", 32'(bus.queue_empty), 32'd1);
    check("rst_ready", 32'(bus.inv_ready), 32'd1);

    // random traffic over a small address pool
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = (i / 500) % 3;
      step($urandom_range(0, 3) < p + 1,
           30'($urandom_range(0, 19)),
           $urandom_range(0, 3) >= p,
           $urandom_range(0, 3) >= p,
           $urandom_range(0, 199) == 0);
    end
    step(0, '0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_inv_queue.md
# instr_inv_queue

Buffers instruction-coherency invalidation requests produced by the data-side store path and delivers each one, line-aligned, to both the instruction cache and the branch predictor. It is the consuming end of the invalidation stream enabled when `INSTRUCTION_COHERENCY` is set, and it is sized by `INSTR_INV_QUEUE_DEPTH`. It exports an empty flag that the IFENCE logic uses to wait until all prior stores are reflected in the fetch path.

## Interface
- `DEPTH`, 4: queue entries; power of 2, ≥2; driven from `INSTR_INV_QUEUE_DEPTH`.
- `LINE_W`, 4: icache line width in words, power of 2; driven from `ICACHE.LINE_W`.
- Derived value `LA_W = 30 - $clog2(LINE_W)`: line-address width.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `inv_valid`  in  1  invalidation request from the store path.
- `inv_addr`  in  30  word address, byte address bits [31:2].
- `inv_ready`  out  1  queue accepts a request this cycle.
- `ic_inv_valid`  out  1  head entry pending for the icache.
- `ic_inv_addr`  out  32  line-aligned byte address; low `2+$clog2(LINE_W)` bits are 0.
- `ic_inv_ack`  in  1  icache consumed the head entry.
- `bp_inv_valid`  out  1  head entry pending for the branch predictor.
- `bp_inv_addr`  out  32  same value as `ic_inv_addr`.
- `bp_inv_ack`  in  1  branch predictor consumed the head entry.
- `queue_empty`  out  1  no entries held; both consumers idle.

## Operation
- Storage:
  - `DEPTH` × `LA_W` line addresses.
  - Read and write pointers of `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - Occupancy counter `count` of `$clog2(DEPTH)+1` bits.
  - Head flags `ic_done` and `bp_done`.
- Line address = `inv_addr[29:$clog2(LINE_W)]`.
- Accept: handshake is `inv_valid && inv_ready`. `inv_ready = (count != DEPTH)`, registered-state only with no combinational path from the acks.
- Coalesce: an accepted request whose line equals the most recently written entry is dropped, and no pointer moves. Coalescing is allowed only when that entry has not been partially served:
  - `count ≥ 2`, or
  - `count == 1` with `ic_done == 0` and `bp_done == 0`.
  - Otherwise the request is written as a new entry.
- Delivery:
  - `ic_inv_valid = (count != 0) && !ic_done`.
  - `bp_inv_valid = (count != 0) && !bp_done`.
  - Both address outputs show the head entry.
- Each consumer acks independently; an ack is meaningful only while that consumer's valid is high.
  - An ack sets the matching done flag unless the pop condition holds in the same cycle.
- Pop when both consumers are done: `(ic_done || ic_inv_ack) && (bp_done || bp_inv_ack)`. On pop:
  - Advance the read pointer.
  - Clear both done flags.
  - Decrement `count`.
- Push and pop in the same cycle leave `count` unchanged. Because `inv_ready` uses registered `count`, a full queue does not accept in the same cycle it pops.
- `queue_empty = (count == 0)`.
- Reset clears pointers, `count`, and done flags. Entry contents are don't-care.
- Reset outputs: `inv_ready=1`, `ic_inv_valid=0`, `bp_inv_valid=0`, `queue_empty=1`. Addresses are don't-care until valid.
- Reset asserted mid-operation discards all entries and partial-ack state.

## Timing
- Enqueue to head visibility: an accepted entry written into an empty queue is presented on `ic_inv_valid`/`bp_inv_valid` the next cycle. There is no same-cycle bypass.
- Minimum service: both acks in the first valid cycle give one entry per cycle throughout.
- Partial ack: after a single consumer's ack, that consumer's valid drops the next cycle. The other consumer's valid holds until its ack. The pop happens in the cycle of the second ack, and the next entry (if any) is presented the cycle after.
- `queue_empty` falls the cycle after the first accept and rises the cycle after the final pop.
- `inv_ready` falls the cycle after `count` reaches `DEPTH`. It rises the cycle after any pop from full.
- All outputs are driven from registers or from registered state plus the storage read. Acks have no combinational path to any output.

## Test plan
- Reset, then a single request `inv_addr=30'h2000_0005` with `LINE_W=4` → next cycle both valids are 1 and both addresses are `32'h8000_0010`. Same-cycle acks → `queue_empty=1` one cycle later.
- Staggered acks: icache acks at cycle 2 and the predictor at cycle 6 → `ic_inv_valid` is 0 from cycle 3, `bp_inv_valid` stays 1 through cycle 6, and a single pop occurs at cycle 6.
- Coalescing: words 0x40, 0x41, 0x43 enqueued back-to-back with no acks → `count=1` and one line (`32'h0000_0100`) is delivered. The sequence 0x40, 0x80, 0x41 → three entries in order.
- Partial-serve guard: single entry at line 0x10 with only the icache acked, then a request to the same line → the request is written as a second entry and delivered to both consumers after the first pops.
- Full and wrap (`DEPTH=4`): five distinct lines with acks held low → `inv_ready=0` after four accepts. Draining all entries, including across a pointer wrap, delivers them in FIFO order with no loss or duplication.
- Reset with three entries pending and the icache half-acked → all valids are 0, `queue_empty=1`, and `inv_ready=1` on the cycle after reset.
